// File: rtl/calc_pkg.sv
// Shared types and constants for the accumulator calculator: FSM states,
// ALU opcodes and the history pointer width helper.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_MUL  = 4'h5;
    localparam logic [3:0] ALU_SHL  = 4'h6;
    localparam logic [3:0] ALU_PASS = 4'h7;

    // Smallest pointer width able to address every history slot (at least 1).
    function automatic int hist_ptr_width(input int depth);
        int w;
        for (w = 0; (1 << w) < depth; w++) begin
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/calc_acc_hist_if.sv
// Board-side bundle of the calculator: buttons and switches in, LEDs and status out.
interface calc_acc_hist_if
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 8
);
    logic                               btnl;
    logic                               btnc;
    logic                               btnr;
    logic                               btnd;
    logic                               btn_undo;
    logic [WIDTH-1:0]                   sw;
    logic [WIDTH-1:0]                   led;
    logic                               ovf;
    logic                               busy;
    logic [hist_ptr_width(HIST_DEPTH):0] hist_cnt;

    modport master (
        output btnl, btnc, btnr, btnd, btn_undo, sw,
        input  led, ovf, busy, hist_cnt
    );

    modport slave (
        input  btnl, btnc, btnr, btnd, btn_undo, sw,
        output led, ovf, busy, hist_cnt
    );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; operands arrive already sign-extended.
module alu
    import calc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  opcode,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        case (opcode)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_MUL:  y = a * b;
            ALU_SHL:  y = a << b[3:0];
            ALU_PASS: y = b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/calc_hist_stack.sv
// Circular LIFO of previous accumulator values; a push when full overwrites the oldest entry.
module calc_hist_stack
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                clear,
    input  logic                                push,
    input  logic                                pop,
    input  logic [WIDTH-1:0]                    push_data,
    output logic [WIDTH-1:0]                    top_data,
    output logic [hist_ptr_width(HIST_DEPTH):0] count
);
    localparam int PTR_W = hist_ptr_width(HIST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [HIST_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;

    // Power-of-two depth lets the pointer wrap naturally, giving overwrite-oldest for free.
    assign top_ptr  = wr_ptr - PTR_W'(1);
    assign top_data = mem[top_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
            if (count != CNT_W'(HIST_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && (count != '0)) begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/decoder.sv
// Maps the three opcode select buttons {btnl, btnc, btnr} onto a 4-bit ALU opcode.
module decoder
    import calc_pkg::*;
(
    input  logic       btnl,
    input  logic       btnc,
    input  logic       btnr,
    output logic [3:0] opcode
);
    always_comb begin
        opcode = ALU_ADD;
        case ({btnl, btnc, btnr})
            3'b000:  opcode = ALU_ADD;
            3'b001:  opcode = ALU_SUB;
            3'b010:  opcode = ALU_AND;
            3'b011:  opcode = ALU_OR;
            3'b100:  opcode = ALU_XOR;
            3'b101:  opcode = ALU_MUL;
            3'b110:  opcode = ALU_SHL;
            default: opcode = ALU_PASS;
        endcase
    end
endmodule

// File: rtl/calc_acc_hist.sv
// Accumulator calculator with press edge detection, three-cycle commit, undo history and overflow flag.
// Optional build macro: CALC_SATURATE_EN (saturate led on signed overflow instead of wrapping).
module calc_acc_hist
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 8
) (
    input  logic            clk,
    input  logic            btnu,
    calc_acc_hist_if.slave  bus
);
    localparam int CNT_W = hist_ptr_width(HIST_DEPTH) + 1;

    state_t             state;
    logic               btnd_q;
    logic               undo_q;
    logic               exec_press;
    logic               undo_press;
    logic [3:0]         dec_op;
    logic [3:0]         opcode;
    logic [31:0]        op1;
    logic [31:0]        op2;
    logic [31:0]        alu_y;
    logic [31:0]        result;
    logic signed [31:0] res_shift;
    logic               ovf_next;
    logic [WIDTH-1:0]   commit_val;
    logic [WIDTH-1:0]   led_q;
    logic               ovf_q;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   hist_top;
    logic [CNT_W-1:0]   hist_cnt;

    decoder u_decoder (
        .btnl   (bus.btnl),
        .btnc   (bus.btnc),
        .btnr   (bus.btnr),
        .opcode (dec_op)
    );

    alu u_alu (
        .a      (op1),
        .b      (op2),
        .opcode (opcode),
        .y      (alu_y)
    );

    calc_hist_stack #(
        .WIDTH      (WIDTH),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .clear     (btnu),
        .push      (push),
        .pop       (pop),
        .push_data (led_q),
        .top_data  (hist_top),
        .count     (hist_cnt)
    );

    assign exec_press = bus.btnd & ~btnd_q;
    assign undo_press = bus.btn_undo & ~undo_q;

    // Result fits in WIDTH signed bits only if everything from bit WIDTH-1 upward is sign copies.
    assign res_shift = $signed(result) >>> (WIDTH - 1);
    assign ovf_next  = (res_shift != '0) && (res_shift != '1);

`ifdef CALC_SATURATE_EN
    assign commit_val = !ovf_next  ? result[WIDTH-1:0] :
                        result[31] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign commit_val = result[WIDTH-1:0];
`endif

    assign push = (state == COMMIT) && !btnu;
    assign pop  = (state == IDLE) && undo_press && !exec_press && !btnu;

    // Edge registers keep tracking levels even in reset, so a held button never fires on release.
    always_ff @(posedge clk) begin
        btnd_q <= bus.btnd;
        undo_q <= bus.btn_undo;
        if (btnu) begin
            state  <= IDLE;
            led_q  <= '0;
            ovf_q  <= 1'b0;
            op1    <= '0;
            op2    <= '0;
            opcode <= ALU_ADD;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exec_press) begin
                        op1    <= {{(32-WIDTH){led_q[WIDTH-1]}}, led_q};
                        op2    <= {{(32-WIDTH){bus.sw[WIDTH-1]}}, bus.sw};
                        opcode <= dec_op;
                        state  <= CALC;
                    end else if (undo_press && (hist_cnt != '0)) begin
                        led_q <= hist_top;
                        ovf_q <= 1'b0;
                    end
                end
                CALC: begin
                    result <= alu_y;
                    state  <= COMMIT;
                end
                COMMIT: begin
                    led_q <= commit_val;
                    ovf_q <= ovf_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led      = led_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = (state != IDLE);
    assign bus.hist_cnt = hist_cnt;
endmodule

// File: tb/tb_calc_acc_hist.sv
// Scoreboard bench for calc_acc_hist: a reference model queues expected led/ovf/hist_cnt per press.
module tb_calc_acc_hist;
    localparam int WIDTH      = 16;
    localparam int HIST_DEPTH = 4;
    localparam int MAXV       = 2 ** (WIDTH - 1) - 1;
    localparam int MINV       = -(2 ** (WIDTH - 1));

    typedef struct {
        logic [WIDTH-1:0] led;
        logic             ovf;
        int               cnt;
    } exp_t;

    logic clk = 1'b0;
    logic btnu;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] model_hist[$];
    logic [WIDTH-1:0] model_acc;
    logic             model_ovf;
    int               vectors     = 0;
    int               miscompares = 0;

    always #5 clk = ~clk;

    calc_acc_hist_if #(.WIDTH(WIDTH), .HIST_DEPTH(HIST_DEPTH)) bus ();

    calc_acc_hist #(.WIDTH(WIDTH), .HIST_DEPTH(HIST_DEPTH)) dut (
        .clk  (clk),
        .btnu (btnu),
        .bus  (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_alu(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a * b;
            3'd6:    return a << b[3:0];
            default: return b;
        endcase
    endfunction

    task automatic model_exec(input logic [2:0] sel, input logic [WIDTH-1:0] swv);
        logic [31:0]        a;
        logic [31:0]        b;
        logic signed [31:0] r;
        logic               ov;
        logic [WIDTH-1:0]   nv;
        a  = {{(32-WIDTH){model_acc[WIDTH-1]}}, model_acc};
        b  = {{(32-WIDTH){swv[WIDTH-1]}}, swv};
        r  = model_alu(sel, a, b);
        ov = (r > MAXV) || (r < MINV);
        nv = r[WIDTH-1:0];
`ifdef CALC_SATURATE_EN
        if (ov) nv = r[31] ? WIDTH'(MINV) : WIDTH'(MAXV);
`endif
        if (model_hist.size() == HIST_DEPTH) void'(model_hist.pop_front());
        model_hist.push_back(model_acc);
        model_acc = nv;
        model_ovf = ov;
        exp_q.push_back('{model_acc, model_ovf, model_hist.size()});
    endtask

    task automatic applyReset();
        @(negedge clk);
        btnu = 1'b1;
        repeat (2) @(negedge clk);
        btnu = 1'b0;
        model_acc = '0;
        model_ovf = 1'b0;
        model_hist.delete();
        checkOutput("rst_led", 32'(bus.led), 32'(0));
        checkOutput("rst_ovf", 32'(bus.ovf), 32'(0));
        checkOutput("rst_busy", 32'(bus.busy), 32'(0));
        checkOutput("rst_cnt", 32'(bus.hist_cnt), 32'(0));
    endtask

    // Execute press: hold = cycles btnd stays high, with_undo = undo rises together,
    // glitch = undo press during CALC and a btnd re-press during COMMIT.
    task automatic applyStimulus(input logic [2:0] sel, input logic [WIDTH-1:0] swv,
                                 input int hold, input bit with_undo, input bit glitch);
        exp_t             e;
        logic [WIDTH-1:0] old_led;
        int               n;
        old_led = model_acc;
        model_exec(sel, swv);
        @(negedge clk);
        {bus.btnl, bus.btnc, bus.btnr} = sel;
        bus.sw       = swv;
        bus.btnd     = 1'b1;
        bus.btn_undo = with_undo;
        n = ((hold > 3) ? hold : 3) + 3;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == hold - 1) bus.btnd = 1'b0;
            if (i == 0) begin
                checkOutput("busy_calc", 32'(bus.busy), 32'(1));
                bus.btn_undo = glitch;
                {bus.btnl, bus.btnc, bus.btnr} = ~sel;
                bus.sw = ~swv;
            end
            if (i == 1) begin
                checkOutput("busy_commit", 32'(bus.busy), 32'(1));
                checkOutput("led_before", 32'(bus.led), 32'(old_led));
                if (glitch) bus.btnd = 1'b1;
            end
            if (i == 2) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_empty", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("exec_led", 32'(bus.led), 32'(e.led));
                    checkOutput("exec_ovf", 32'(bus.ovf), 32'(e.ovf));
                    checkOutput("exec_cnt", 32'(bus.hist_cnt), 32'(e.cnt));
                end
                checkOutput("busy_done", 32'(bus.busy), 32'(0));
                if (glitch) begin
                    bus.btnd     = 1'b0;
                    bus.btn_undo = 1'b0;
                end
            end
        end
        bus.btnd     = 1'b0;
        bus.btn_undo = 1'b0;
        checkOutput("led_stable", 32'(bus.led), 32'(model_acc));
        checkOutput("cnt_stable", 32'(bus.hist_cnt), 32'(model_hist.size()));
    endtask

    task automatic applyUndo();
        exp_t e;
        if (model_hist.size() > 0) begin
            model_acc = model_hist.pop_back();
            model_ovf = 1'b0;
        end
        exp_q.push_back('{model_acc, model_ovf, model_hist.size()});
        @(negedge clk);
        bus.btn_undo = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        checkOutput("undo_led", 32'(bus.led), 32'(e.led));
        checkOutput("undo_ovf", 32'(bus.ovf), 32'(e.ovf));
        checkOutput("undo_cnt", 32'(bus.hist_cnt), 32'(e.cnt));
        checkOutput("undo_busy", 32'(bus.busy), 32'(0));
        bus.btn_undo = 1'b0;
    endtask

    initial begin
        btnu         = 1'b1;
        bus.btnl     = 1'b0;
        bus.btnc     = 1'b0;
        bus.btnr     = 1'b0;
        bus.btnd     = 1'b0;
        bus.btn_undo = 1'b0;
        bus.sw       = '0;
        applyReset();

        applyStimulus(3'd0, 16'h0005, 1, 1'b0, 1'b0);
        applyStimulus(3'd0, 16'hFFFD, 1, 1'b0, 1'b0);
        repeat (3) applyUndo();

        applyStimulus(3'd7, 16'h7FFF, 1, 1'b0, 1'b0);
        applyStimulus(3'd0, 16'h0001, 1, 1'b0, 1'b0);
        applyUndo();
        applyStimulus(3'd1, 16'h0003, 1, 1'b0, 1'b0);
        applyStimulus(3'd4, 16'h00FF, 1, 1'b0, 1'b0);
        applyStimulus(3'd5, 16'h0002, 1, 1'b0, 1'b0);
        applyStimulus(3'd6, 16'h0003, 1, 1'b0, 1'b0);

        applyStimulus(3'd0, 16'h0001, 20, 1'b0, 1'b0);
        applyStimulus(3'd0, 16'h0001, 1, 1'b1, 1'b0);
        applyStimulus(3'd0, 16'h0001, 1, 1'b0, 1'b1);

        // Reset in the CALC cycle with btnd held through release.
        @(negedge clk);
        bus.sw   = 16'h0005;
        {bus.btnl, bus.btnc, bus.btnr} = 3'd0;
        bus.btnd = 1'b1;
        @(negedge clk);
        checkOutput("mid_busy", 32'(bus.busy), 32'(1));
        btnu = 1'b1;
        @(negedge clk);
        btnu = 1'b0;
        model_acc = '0;
        model_ovf = 1'b0;
        model_hist.delete();
        checkOutput("mid_rst_led", 32'(bus.led), 32'(0));
        checkOutput("mid_rst_cnt", 32'(bus.hist_cnt), 32'(0));
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'(0));
        repeat (5) @(negedge clk);
        checkOutput("held_led", 32'(bus.led), 32'(0));
        checkOutput("held_cnt", 32'(bus.hist_cnt), 32'(0));
        checkOutput("held_busy", 32'(bus.busy), 32'(0));
        bus.btnd = 1'b0;

        for (int k = 0; k < 6; k++) applyStimulus(3'd0, 16'h0001, 1, 1'b0, 1'b0);
        repeat (5) applyUndo();

        applyReset();
        applyStimulus(3'd7, 16'h8000, 1, 1'b0, 1'b0);
        applyStimulus(3'd1, 16'h0001, 1, 1'b0, 1'b0);
        applyUndo();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
